// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Data-side memory for the accumulator CPU. Answers CPU
//                rd/wr requests with one-cycle registered read data and
//                contains a dump engine that streams words 0..DUMP_WORDS-1
//                over a valid/ready port for the debug unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 2048,
    parameter int DUMP_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              err_rdwr,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_fetch   = 2'd1;
    localparam logic [1:0] c_present = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(DUMP_WORDS - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              w_cpu_en;
    logic              w_addr_ok;
    logic              w_last;

    // CPU traffic is locked out for the whole dump so the streamed image is coherent
    assign w_cpu_en  = ~dump_busy;
    assign w_addr_ok = (32'(addr) < 32'(DEPTH));
    assign w_last    = (r_ptr == c_last_ptr);

    // Storage array: never reset, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (wr && w_cpu_en && w_addr_ok) begin
            r_mem[addr] <= in_data;
        end
    end

    // CPU read port (read-first on rd&wr) and sticky collision flag
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            err_rdwr <= 1'b0;
        end else if (w_cpu_en) begin
            if (rd) begin
                out_data <= w_addr_ok ? r_mem[addr] : '0;
            end
            if (rd && wr) begin
                err_rdwr <= 1'b1;
            end
        end
    end

    // Dump FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dump FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:    if (dump_start) w_next_state = c_fetch;
            c_fetch:   w_next_state = c_present;
            c_present: if (dump_ready) w_next_state = w_last ? c_done : c_fetch;
            c_done:    w_next_state = c_idle;
            default:   w_next_state = c_idle;
        endcase
    end

    // Dump FSM decoded outputs
    always_comb begin
        dump_busy  = (r_state != c_idle);
        dump_valid = (r_state == c_present);
        dump_done  = (r_state == c_done);
    end

    // Dump pointer and presented word; held steady while waiting for ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= '0;
            dump_addr <= '0;
            dump_data <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (dump_start) r_ptr <= '0;
                end
                c_fetch: begin
                    dump_data <= r_mem[r_ptr];
                    dump_addr <= r_ptr;
                end
                c_present: begin
                    if (dump_ready && !w_last) r_ptr <= r_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Directed self-checking bench for data_memory (CPU port,
//                read/write collision, dump engine with stalls and reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;
    logic              err_rdwr;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    int tests;
    int fails;

    data_memory #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (2048),
        .DUMP_WORDS(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .in_data   (in_data),
        .out_data  (out_data),
        .err_rdwr  (err_rdwr),
        .dump_start(dump_start),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .dump_done (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before checking/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check every dump-port output in one call
    task automatic check_dump(input string tag, input logic busy, input logic valid,
                              input logic done, input logic [31:0] a, input logic [31:0] d);
        check({tag, ".busy"},  32'(dump_busy),  32'(busy));
        check({tag, ".valid"}, 32'(dump_valid), 32'(valid));
        check({tag, ".done"},  32'(dump_done),  32'(done));
        check({tag, ".addr"},  32'(dump_addr),  a);
        check({tag, ".data"},  32'(dump_data),  d);
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr = 1'b1; rd = 1'b0; addr = a; in_data = d;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; in_data = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst.out_data", 32'(out_data), 32'h0);
        check("rst.err_rdwr", 32'(err_rdwr), 32'h0);
        check_dump("rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Basic write/read, including the top address
        cpu_write(11'd5, 16'h1234);
        cpu_write(11'd2047, 16'hBEEF);
        rd = 1'b1; addr = 11'd5;
        tick();
        check("rd5", 32'(out_data), 32'h1234);
        addr = 11'd2047;
        tick();
        check("rd2047", 32'(out_data), 32'hBEEF);
        rd = 1'b0; addr = 11'd5;
        tick();
        check("hold", 32'(out_data), 32'hBEEF);

        // Read/write collision: read-first, write lands, sticky error
        cpu_write(11'd7, 16'hAAAA);
        rd = 1'b1; wr = 1'b1; addr = 11'd7; in_data = 16'h5555;
        tick();
        check("rdwr.old", 32'(out_data), 32'hAAAA);
        check("rdwr.err", 32'(err_rdwr), 32'h1);
        wr = 1'b0;
        tick();
        check("rdwr.new", 32'(out_data), 32'h5555);
        check("rdwr.sticky", 32'(err_rdwr), 32'h1);
        rd = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rdwr.rst_err", 32'(err_rdwr), 32'h0);
        check("rdwr.rst_out", 32'(out_data), 32'h0);

        // Preload dump image
        for (int i = 0; i < 4; i++) cpu_write(ADDR_W'(i), DATA_W'(16'h10 + i));

        // Dump 1: ready held high; CPU write and second start attempted mid-dump
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check_dump("d1.fetch0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                wr = 1'b1; addr = 11'd0; in_data = 16'hFFFF; dump_start = 1'b1;
            end
            tick();
            wr = 1'b0; dump_start = 1'b0;
            check_dump($sformatf("d1.beat%0d", k), 1'b1, 1'b1, 1'b0, 32'(k), 32'(16'h10 + k));
            tick();
            if (k < 3) check_dump($sformatf("d1.gap%0d", k), 1'b1, 1'b0, 1'b0, 32'(k), 32'(16'h10 + k));
        end
        check_dump("d1.done", 1'b1, 1'b0, 1'b1, 32'h3, 32'h13);
        tick();
        check_dump("d1.idle", 1'b0, 1'b0, 1'b0, 32'h3, 32'h13);
        tick(); tick();
        check("d1.no_restart", 32'(dump_busy), 32'h0);
        rd = 1'b1; addr = 11'd0;
        tick();
        rd = 1'b0;
        check("d1.mem0_kept", 32'(out_data), 32'h10);

        // Dump 2: ready low for three cycles while beat 1 is presented
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        check_dump("d2.beat0", 1'b1, 1'b1, 1'b0, 32'h0, 32'h10);
        tick();
        dump_ready = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            check_dump($sformatf("d2.stall%0d", s), 1'b1, 1'b1, 1'b0, 32'h1, 32'h11);
            tick();
        end
        check_dump("d2.stall3", 1'b1, 1'b1, 1'b0, 32'h1, 32'h11);
        dump_ready = 1'b1;
        tick();
        check("d2.accept1", 32'(dump_valid), 32'h0);
        tick();
        check_dump("d2.beat2", 1'b1, 1'b1, 1'b0, 32'h2, 32'h12);
        tick(); tick();
        check_dump("d2.beat3", 1'b1, 1'b1, 1'b0, 32'h3, 32'h13);
        tick();
        check("d2.done", 32'(dump_done), 32'h1);
        tick();
        check("d2.idle", 32'(dump_busy), 32'h0);

        // Dump 3: reset while presenting beat 2, then restart from address 0
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int e = 0; e < 5; e++) tick();
        check_dump("d3.beat2", 1'b1, 1'b1, 1'b0, 32'h2, 32'h12);
        dump_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_dump("d3.reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("d3.no_done", 32'(dump_done), 32'h0);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        check_dump("d3.restart", 1'b1, 1'b1, 1'b0, 32'h0, 32'h10);
        begin
            int budget;
            budget = 20;
            while (!dump_done && budget > 0) begin
                tick();
                budget--;
            end
            check("d3.done_seen", 32'(dump_done), 32'h1);
            check("d3.final_addr", 32'(dump_addr), 32'h3);
        end
        tick();
        check("d3.idle", 32'(dump_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
